// File: rtl/uart_pkg.sv
// uart_pkg: shared state encoding and parity-mode constants for the UART transmitter.
// The PARITY state exists only when UART_TX_PARITY_EN is defined.
package uart_pkg;

`ifdef UART_TX_PARITY_EN
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
    typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
`endif

    localparam logic [1:0] PAR_NONE = 2'b00;
    localparam logic [1:0] PAR_EVEN = 2'b01;
    localparam logic [1:0] PAR_ODD  = 2'b10;

    function automatic logic parity_enabled(input logic [1:0] mode);
        return mode == PAR_EVEN || mode == PAR_ODD;
    endfunction

endpackage

// File: rtl/uart_baud_cnt.sv
// uart_baud_cnt: loadable bit-period down-counter; tick is high while the count sits at zero.
module uart_baud_cnt #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         tick
);

    logic [W-1:0] cnt;

    always_ff @(posedge clk or posedge rst)
        if (rst)
            cnt <= '0;
        else if (load)
            cnt <= load_val;
        else if (cnt != '0)
            cnt <= cnt - 1'b1;

    assign tick = cnt == '0;

endmodule

// File: rtl/uart_tx_param.sv
// uart_tx_param: parameterised UART transmitter (start, DATA_W bits LSB first, optional parity, 1 or 2 stops).
// Parity generation is present only when UART_TX_PARITY_EN is defined.
module uart_tx_param
    import uart_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int DIV_W  = 16
) (
    input  logic              i_Clock,
    input  logic              i_Reset,
    input  logic [DIV_W-1:0]  i_Clks_Per_Bit,
    input  logic              i_Two_Stop,
    input  logic [1:0]        i_Parity_Mode,
    input  logic              i_Tx_DV,
    input  logic [DATA_W-1:0] i_Tx_Byte,
    output logic              o_Tx_Ready,
    output logic              o_Tx_Active,
    output logic              o_Tx_Serial,
    output logic              o_Tx_Done
);

    localparam int IDX_W = $clog2(DATA_W);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_W - 1);

    state_t              state;
    logic [DATA_W-1:0]   shreg;
    logic [IDX_W-1:0]    idx;
    logic [DIV_W-1:0]    div_reg;
    logic [DIV_W-1:0]    div_in;
    logic [DIV_W-1:0]    load_val;
    logic                two_stop;
    logic                stop_cnt;
    logic                tick;
    logic                load;
    logic                accept;

`ifdef UART_TX_PARITY_EN
    logic par_en;
    logic par_bit;
`else
    logic unused_par;
    assign unused_par = ^i_Parity_Mode;
`endif

    assign div_in   = (i_Clks_Per_Bit == '0) ? DIV_W'(1) : i_Clks_Per_Bit;
    assign accept   = i_Tx_DV && state == IDLE;
    assign load     = accept || (state != IDLE && tick);
    assign load_val = accept ? div_in - 1'b1 : div_reg - 1'b1;

    uart_baud_cnt #(.W(DIV_W)) u_baud (
        .clk      (i_Clock),
        .rst      (i_Reset),
        .load     (load),
        .load_val (load_val),
        .tick     (tick)
    );

    always_ff @(posedge i_Clock or posedge i_Reset) begin
        if (i_Reset) begin
            state       <= IDLE;
            shreg       <= '0;
            idx         <= '0;
            div_reg     <= '0;
            two_stop    <= 1'b0;
            stop_cnt    <= 1'b0;
            o_Tx_Serial <= 1'b1;
            o_Tx_Active <= 1'b0;
            o_Tx_Done   <= 1'b0;
            o_Tx_Ready  <= 1'b1;
`ifdef UART_TX_PARITY_EN
            par_en      <= 1'b0;
            par_bit     <= 1'b0;
`endif
        end else begin
            o_Tx_Done <= 1'b0;
            case (state)
                IDLE: if (accept) begin
                    shreg       <= i_Tx_Byte;
                    div_reg     <= div_in;
                    two_stop    <= i_Two_Stop;
                    idx         <= '0;
                    stop_cnt    <= 1'b0;
`ifdef UART_TX_PARITY_EN
                    par_en      <= parity_enabled(i_Parity_Mode);
                    par_bit     <= (^i_Tx_Byte) ^ (i_Parity_Mode == PAR_ODD);
`endif
                    state       <= START;
                    o_Tx_Serial <= 1'b0;
                    o_Tx_Active <= 1'b1;
                    o_Tx_Ready  <= 1'b0;
                end
                START: if (tick) begin
                    state       <= DATA;
                    o_Tx_Serial <= shreg[0];
                end
                DATA: if (tick) begin
                    shreg <= shreg >> 1;
                    if (idx == LAST_IDX) begin
                        idx <= '0;
`ifdef UART_TX_PARITY_EN
                        state       <= par_en ? PARITY : STOP;
                        o_Tx_Serial <= par_en ? par_bit : 1'b1;
`else
                        state       <= STOP;
                        o_Tx_Serial <= 1'b1;
`endif
                    end else begin
                        idx         <= idx + 1'b1;
                        o_Tx_Serial <= shreg[1];
                    end
                end
`ifdef UART_TX_PARITY_EN
                PARITY: if (tick) begin
                    state       <= STOP;
                    o_Tx_Serial <= 1'b1;
                end
`endif
                STOP: if (tick) begin
                    // A second stop period is counted with a one-bit flag rather than a new state.
                    if (two_stop && !stop_cnt) begin
                        stop_cnt <= 1'b1;
                    end else begin
                        stop_cnt    <= 1'b0;
                        state       <= IDLE;
                        o_Tx_Active <= 1'b0;
                        o_Tx_Ready  <= 1'b1;
                        o_Tx_Done   <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/uart_tx_param.md
UART_TX_PARAM -- requirements
Module: uart_tx_param

Interface
REQ-001 SHALL have parameter DATA_W, default 8, meaning data bits per frame (legal 5..9).
REQ-002 SHALL have parameter DIV_W, default 16, meaning width of the bit-period divisor input.
REQ-003 SHALL have port i_Clock  input  1  sole clock, all state updates on its rising edge.
REQ-004 SHALL have port i_Reset  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port i_Clks_Per_Bit  input  DIV_W  clocks per serial bit; 0 treated as 1.
REQ-006 SHALL have port i_Two_Stop  input  1  1 = two stop bits, 0 = one.
REQ-007 SHALL have port i_Parity_Mode  input  2  00 none, 01 even, 10 odd, 11 none.
REQ-008 SHALL have port i_Tx_DV  input  1  byte-valid strobe.
REQ-009 SHALL have port i_Tx_Byte  input  DATA_W  data to send, LSB first.
REQ-010 SHALL have port o_Tx_Ready  output  1  high only in IDLE; i_Tx_DV accepted only when high.
REQ-011 SHALL have port o_Tx_Active  output  1  high from accept edge until the final stop bit completes.
REQ-012 SHALL have port o_Tx_Serial  output  1  registered serial line, idle high.
REQ-013 SHALL have port o_Tx_Done  output  1  one-cycle pulse at frame end.

Function
REQ-014 SHALL implement states IDLE, START, DATA, PARITY, STOP.
REQ-015 SHALL, on the edge where i_Tx_DV=1 and o_Tx_Ready=1, capture i_Tx_Byte, i_Clks_Per_Bit, i_Two_Stop, i_Parity_Mode, enter START, and drive o_Tx_Serial low from that edge.
REQ-016 SHALL hold every bit (start, data, parity, stop) for exactly the captured divisor count of cycles using a single down-counter reloaded per bit.
REQ-017 SHALL send DATA_W data bits LSB first; the bit index wraps to 0 on leaving DATA.
REQ-018 SHALL enter PARITY after DATA only when parity is enabled, sending XOR of data bits (even) or its inverse (odd); otherwise DATA goes directly to STOP.
REQ-019 SHALL hold o_Tx_Serial high for one or two bit periods in STOP per captured i_Two_Stop.
REQ-020 SHALL, on the edge ending the last stop bit, return to IDLE, deassert o_Tx_Active and pulse o_Tx_Done for exactly one cycle.
REQ-021 SHALL accept a new i_Tx_DV on the cycle o_Tx_Done is high, giving back-to-back frames with no idle gap beyond the stop bits.
REQ-022 SHALL ignore i_Tx_DV while o_Tx_Ready=0; configuration input changes mid-frame SHALL not affect the frame in progress.
REQ-023 SHALL have total frame length of (1 + DATA_W + P + S) x divisor cycles, P in {0,1}, S in {1,2}.

Reset
REQ-024 SHALL, while i_Reset=1, force IDLE, o_Tx_Serial=1, o_Tx_Active=0, o_Tx_Done=0, o_Tx_Ready=1, counters and bit index to 0, regardless of clock.
REQ-025 SHALL abort any frame in progress on reset without o_Tx_Done pulse; the line returns high immediately.

Configuration
REQ-026 SHALL gate parity logic with macro UART_TX_PARITY_EN: defined, REQ-018 applies; undefined, the PARITY state and parity generator are absent, i_Parity_Mode is ignored and P=0.

Structure
REQ-027 SHALL place state encoding type, parity-mode constants (PAR_NONE, PAR_EVEN, PAR_ODD) in shared package uart_pkg.
REQ-028 SHALL implement the bit-period counter as sub-module uart_baud_cnt (load, tick-on-expiry).

Verification
REQ-029 DATA_W=8, divisor 4, no parity, one stop, byte 0xA5 -> line 0,1,0,1,0,0,1,0,1,1 each 4 cycles, Done pulse at cycle 40, Active high 40 cycles.
REQ-030 Parity macro defined, divisor 2, even parity, byte 0x07 -> parity bit 1; odd parity -> 0; frame 22 cycles.
REQ-031 Two stop bits, divisor 3, byte 0x00 -> line high 6 cycles after data, Done at cycle 33.
REQ-032 DV asserted on Done cycle with byte 0x3C -> start bit begins immediately, no extra idle cycles.
REQ-033 i_Reset asserted mid-DATA at bit 3 -> line high, Active 0, Ready 1 asynchronously, no Done pulse; next DV sends full frame.
REQ-034 Divisor 0 with byte 0xFF -> each bit lasts 1 cycle, frame 10 cycles; DV during frame ignored.
